// File: rtl/pipe_stage_chain.sv
// Elastic chain of pipeline registers with valid/ready back-pressure,
// per-stage flush and saturating occupancy, stall and drop statistics.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  input  logic [STAGES-1:0]           flush_mask,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0]            stall_count,
  output logic [CNT_W-1:0]            drop_count
);

  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  stageData [STAGES];
  logic [STAGES-1:0] stageValid;
  logic [STAGES-1:0] stageLive;
  logic [STAGES-1:0] stageReady;
  logic [OCC_W-1:0]  validCount;
  logic [OCC_W-1:0]  dropNum;
  logic [SUM_W-1:0]  dropSum;
  logic              stallNow;

  // A flushed occupant counts as empty in the same cycle, so it neither
  // advances nor blocks the stage from accepting a new item.
  assign stageLive = stageValid & ~flush_mask;

  // Ready ripples from the consumer back toward the producer.
  always_comb begin
    logic downReady;
    downReady  = out_ready;
    stageReady = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      downReady     = !stageLive[i] || downReady;
      stageReady[i] = downReady;
    end
  end

  assign in_ready  = stageReady[0];
  assign out_valid = stageLive[STAGES-1];
  assign out_data  = stageData[STAGES-1];

  always_comb begin
    validCount = '0;
    dropNum    = '0;
    for (int i = 0; i < STAGES; i++) begin
      validCount = validCount + OCC_W'(stageValid[i]);
      dropNum    = dropNum + OCC_W'(stageValid[i] & flush_mask[i]);
    end
  end

  assign occupancy = validCount;
  assign stallNow  = out_valid && !out_ready;
  assign dropSum   = SUM_W'(drop_count) + SUM_W'(dropNum);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stageValid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stageData[i] <= '0;
      end
    end else begin
      if (stageReady[0]) begin
        stageData[0]  <= in_data;
        stageValid[0] <= in_valid;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (stageReady[i]) begin
          stageData[i]  <= stageData[i-1];
          stageValid[i] <= stageLive[i-1];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_count <= '0;
      drop_count  <= '0;
    end else begin
      if (stallNow && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      // Several stages may be flushed at once, so the add is clamped rather
      // than simply stopped at the maximum.
      if (dropSum > SUM_W'(CNT_MAX)) begin
        drop_count <= CNT_MAX;
      end else begin
        drop_count <= dropSum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=3, CNT_W=4): vector table plus
// hand sequences for counter saturation and mid-stream reset.
module tb_pipe_stage_chain;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
  localparam int OCC_W  = $clog2(STAGES + 1);

  logic              Clk = 1'b0;
  logic              Rst;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic [STAGES-1:0] flush_mask;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  drop_count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush_mask (flush_mask),
    .occupancy  (occupancy),
    .stall_count(stall_count),
    .drop_count (drop_count)
  );

  typedef struct {
    logic              inValid;
    logic [WIDTH-1:0]  inData;
    logic              outReady;
    logic [STAGES-1:0] flush;
    logic              expInReady;
    logic              expOutValid;
    logic [WIDTH-1:0]  expOutData;
    logic [OCC_W-1:0]  expOcc;
    logic [CNT_W-1:0]  expStall;
    logic [CNT_W-1:0]  expDrop;
  } vec_t;

  vec_t vecs[$];

  function automatic void addV(int iv, int d, int ordy, int fl, int ir, int ov,
                               int od, int occ, int st, int dr);
    vec_t v;
    v.inValid     = 1'(iv);
    v.inData      = WIDTH'(d);
    v.outReady    = 1'(ordy);
    v.flush       = STAGES'(fl);
    v.expInReady  = 1'(ir);
    v.expOutValid = 1'(ov);
    v.expOutData  = WIDTH'(od);
    v.expOcc      = OCC_W'(occ);
    v.expStall    = CNT_W'(st);
    v.expDrop     = CNT_W'(dr);
    vecs.push_back(v);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    flush_mask = '0;

    //   iv  data  ordy fl  ir ov outData occ stall drop
    // streaming 1..5
    addV(1, 32'h1, 1, 0,  1, 0, 0,      0, 0, 0);
    addV(1, 32'h2, 1, 0,  1, 0, 0,      1, 0, 0);
    addV(1, 32'h3, 1, 0,  1, 0, 0,      2, 0, 0);
    addV(1, 32'h4, 1, 0,  1, 1, 32'h1,  3, 0, 0);
    addV(1, 32'h5, 1, 0,  1, 1, 32'h2,  3, 0, 0);
    addV(0, 0,     1, 0,  1, 1, 32'h3,  3, 0, 0);
    addV(0, 0,     1, 0,  1, 1, 32'h4,  2, 0, 0);
    addV(0, 0,     1, 0,  1, 1, 32'h5,  1, 0, 0);
    addV(0, 0,     1, 0,  1, 0, 0,      0, 0, 0);
    // back-pressure A,B,C held 4 cycles
    addV(1, 32'hA, 1, 0,  1, 0, 0,      0, 0, 0);
    addV(1, 32'hB, 1, 0,  1, 0, 0,      1, 0, 0);
    addV(1, 32'hC, 1, 0,  1, 0, 0,      2, 0, 0);
    addV(0, 0,     0, 0,  0, 1, 32'hA,  3, 0, 0);
    addV(0, 0,     0, 0,  0, 1, 32'hA,  3, 1, 0);
    addV(0, 0,     0, 0,  0, 1, 32'hA,  3, 2, 0);
    addV(0, 0,     0, 0,  0, 1, 32'hA,  3, 3, 0);
    addV(0, 0,     1, 0,  1, 1, 32'hA,  3, 4, 0);
    addV(0, 0,     1, 0,  1, 1, 32'hB,  2, 4, 0);
    addV(0, 0,     1, 0,  1, 1, 32'hC,  1, 4, 0);
    addV(0, 0,     1, 0,  1, 0, 0,      0, 4, 0);
    // flush middle stage holding 0x22
    addV(1, 32'h33, 1, 0, 1, 0, 0,      0, 4, 0);
    addV(1, 32'h22, 1, 0, 1, 0, 0,      1, 4, 0);
    addV(1, 32'h11, 1, 0, 1, 0, 0,      2, 4, 0);
    addV(0, 0,      1, 2, 1, 1, 32'h33, 3, 4, 0);
    addV(0, 0,      1, 0, 1, 0, 0,      1, 4, 1);
    addV(0, 0,      1, 0, 1, 1, 32'h11, 1, 4, 1);
    addV(0, 0,      1, 0, 1, 0, 0,      0, 4, 1);
    // flush stage 0 while a new item enters it
    addV(1, 32'h44, 1, 0, 1, 0, 0,      0, 4, 1);
    addV(1, 32'h55, 1, 1, 1, 0, 0,      1, 4, 1);
    addV(0, 0,      1, 0, 1, 0, 0,      1, 4, 2);
    addV(0, 0,      1, 0, 1, 0, 0,      1, 4, 2);
    addV(0, 0,      1, 0, 1, 1, 32'h55, 1, 4, 2);
    addV(0, 0,      1, 0, 1, 0, 0,      0, 4, 2);
    // two stages flushed at once, output stage flushed while consumer stalls
    addV(1, 32'h01, 1, 0, 1, 0, 0,      0, 4, 2);
    addV(1, 32'h02, 1, 0, 1, 0, 0,      1, 4, 2);
    addV(1, 32'h03, 1, 0, 1, 0, 0,      2, 4, 2);
    addV(0, 0,      0, 5, 1, 0, 0,      3, 4, 2);
    addV(0, 0,      1, 0, 1, 1, 32'h02, 1, 4, 4);
    addV(0, 0,      1, 0, 1, 0, 0,      0, 4, 4);

    tick();
    tick();
    Rst = 1'b0;

    chk("reset outData", out_data, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid   = vecs[i].inValid;
      in_data    = vecs[i].inData;
      out_ready  = vecs[i].outReady;
      flush_mask = vecs[i].flush;
      #1;
      chk($sformatf("vec%0d inReady", i), 32'(in_ready), 32'(vecs[i].expInReady));
      chk($sformatf("vec%0d outValid", i), 32'(out_valid), 32'(vecs[i].expOutValid));
      if (vecs[i].expOutValid)
        chk($sformatf("vec%0d outData", i), out_data, vecs[i].expOutData);
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vecs[i].expOcc));
      chk($sformatf("vec%0d stallCount", i), 32'(stall_count), 32'(vecs[i].expStall));
      chk($sformatf("vec%0d dropCount", i), 32'(drop_count), 32'(vecs[i].expDrop));
      tick();
    end
    flush_mask = '0;

    // stall counter saturation: one item parked at the output, consumer idle
    in_valid  = 1'b1;
    in_data   = 32'h66;
    out_ready = 1'b0;
    #1;
    chk("sat inReady", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sat stall k%0d", k), 32'(stall_count),
          (4 + k > 15) ? 32'd15 : 32'(4 + k));
      chk($sformatf("sat outValid k%0d", k), 32'(out_valid), 32'h1);
      tick();
    end
    chk("sat stall final", 32'(stall_count), 32'd15);
    chk("sat outData", out_data, 32'h66);
    chk("sat occupancy", 32'(occupancy), 32'd1);
    chk("sat dropCount", 32'(drop_count), 32'd4);

    // reset with two items in flight
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    tick();
    in_data = 32'h88;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    chk("prerst occupancy", 32'(occupancy), 32'd2);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    chk("rst outValid", 32'(out_valid), 32'h0);
    chk("rst occupancy", 32'(occupancy), 32'd0);
    chk("rst stallCount", 32'(stall_count), 32'd0);
    chk("rst dropCount", 32'(drop_count), 32'd0);
    chk("rst inReady", 32'(in_ready), 32'h1);
    chk("rst outData", out_data, 32'h0);

    // latency after reset: accept at one edge, visible after two more
    in_valid = 1'b1;
    in_data  = 32'h99;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    chk("lat early outValid", 32'(out_valid), 32'h0);
    tick();
    chk("lat outValid", 32'(out_valid), 32'h1);
    chk("lat outData", out_data, 32'h99);
    tick();
    chk("lat drained", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, elastic chain of pipeline registers.
- Replaces the hand-wired, always-advancing inter-stage registers between pipeline stages with one generic block.
- Adds per-stage valid bits, valid/ready back-pressure (stall), per-stage flush (squash), and saturating occupancy, stall and drop counters.
- Sits between any producer stage and consumer stage in the datapath; one instance per pipeline segment.

Parameters:
WIDTH, 32, payload bits carried per stage (control and data fields concatenated by the instantiator)
STAGES, 4, number of register stages in the chain (>=1)
CNT_W, 16, width of the stall and drop counters

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst  input  1  synchronous, active-high reset
in_valid  input  1  producer presents an item
in_data  input  WIDTH  producer payload
in_ready  output  1  chain accepts in_data this cycle
out_valid  output  1  last stage holds a live item
out_data  output  WIDTH  last-stage payload
out_ready  input  1  consumer accepts out_data this cycle
flush_mask  input  STAGES  bit i kills the current occupant of stage i (bit 0 = input-side stage)
occupancy  output  $clog2(STAGES+1)  number of live stages
stall_count  output  CNT_W  saturating count of cycles with out_valid && !out_ready
drop_count  output  CNT_W  saturating count of live items killed by flush_mask

Behaviour:
- Reset: all valid[i]=0 and all data[i]=0. Therefore out_valid=0, out_data=0, occupancy=0, stall_count=0, drop_count=0. in_ready=1, because the chain is empty (combinational).
- Reset mid-operation discards all in-flight items. Nothing is counted as dropped.
- Per-stage liveness: live[i] = valid[i] && !flush_mask[i]. A flushed stage behaves as empty in the same cycle.
- Ready chain (combinational, output side to input side):
  - rdy[STAGES-1] = !live[STAGES-1] || out_ready.
  - rdy[i] = !live[i] || rdy[i+1].
  - in_ready = rdy[0].
- out_valid = live[STAGES-1]. out_data = data[STAGES-1] (valid only when out_valid=1).
- Transfer rule at each edge:
  - Stage 0 loads in_data and sets valid[0] = in_valid when rdy[0]=1.
  - Stage i>0 loads data[i-1] and sets valid[i] = live[i-1] when rdy[i]=1.
  - When rdy[i]=0, stage i holds both data and valid.
- Flush:
  - A flushed occupant never advances and never appears on out_valid.
  - A new item may enter a flushed stage in the same cycle. Flush kills only the current occupant.
  - drop_count increments once per cycle by the number of i with valid[i] && flush_mask[i]. It saturates at 2^CNT_W-1 (adds are clamped).
- Latency: with no back-pressure and no flush, an item accepted at edge k appears on out_valid after edge k+STAGES-1, i.e. STAGES cycles of latency. Throughput is 1 item/cycle.
- Full chain with out_ready=0: in_ready=0 and all stages hold. A producer must keep in_valid/in_data stable until in_ready=1; the block does not check this.
- Simultaneous full and draining: with out_ready=1 on a full chain, all stages shift and a new item is accepted in the same cycle. There are no bubbles.
- occupancy = popcount(valid), registered state only (pre-flush, pre-transfer).
- stall_count increments each cycle out_valid && !out_ready and saturates at 2^CNT_W-1.
- out_data of an empty stage is don't-care, but it must not be X after reset.

Test Plan:
- Streaming, STAGES=3, WIDTH=32, out_ready=1: inject 0x00000001..0x00000005 on consecutive cycles -> outputs appear in order starting exactly 3 cycles after first accept, one per cycle. occupancy peaks at 3. stall_count=0.
- Back-pressure: fill with 0xA, 0xB, 0xC, then hold out_ready=0 for 4 cycles -> in_ready=0, out_data=0xA held, occupancy=3, stall_count=4. Release -> 0xA, 0xB, 0xC drain in order with no loss or duplication.
- Flush: chain holds 0x11 (stage0), 0x22 (stage1), 0x33 (stage2), out_ready=1, flush_mask=3'b010 for one cycle -> 0x22 never emitted, drop_count=1, output sequence 0x33, 0x11.
- Flush with entry: flush_mask=3'b001 while stage 0 holds 0x44 and in_valid=1 with 0x55 -> 0x44 dropped, 0x55 enters stage 0, drop_count increments by 1.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_count stops at 15.
- Reset mid-stream: assert Rst for 1 cycle with 2 items live -> next cycle out_valid=0, occupancy=0, all counters 0, in_ready=1.
